// File: rtl/bsg_sdr_test_node_sequencer.sv
// Sequences SDR test nodes one at a time: fixed-length burst, drain, error check, report.
// Optional drain timeout is built when BSG_SDR_TEST_SEQ_TIMEOUT_EN is defined.
module bsg_sdr_test_node_sequencer #(
    parameter int unsigned num_nodes_p      = 4,
    parameter int unsigned count_width_p    = 32,
    parameter int unsigned timeout_width_p  = 16,
    localparam int unsigned node_id_width_lp = (num_nodes_p > 1) ? $clog2(num_nodes_p) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    input  logic                                 start_i,
    input  logic [count_width_p-1:0]             burst_len_i,
    output logic [num_nodes_p-1:0]               en_o,
    input  logic [num_nodes_p*count_width_p-1:0] sent_i,
    input  logic [num_nodes_p*count_width_p-1:0] received_i,
    input  logic [num_nodes_p-1:0]               error_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 pass_o,
    output logic [node_id_width_lp-1:0]          fail_node_o,
    output logic                                 timeout_o
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SEND  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]                  state_q, state_d;
    logic [node_id_width_lp-1:0] idx_q, idx_d;
    logic [count_width_p-1:0]    burst_q, burst_d;
    logic [count_width_p-1:0]    base_s_q, base_s_d;
    logic [count_width_p-1:0]    base_r_q, base_r_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        pass_q, pass_d;
    logic [node_id_width_lp-1:0] fail_node_q, fail_node_d;

    logic [count_width_p-1:0]    sent_sel, recv_sel, ds, dr;
    logic                        err_sel;
    logic                        last_node;

`ifdef BSG_SDR_TEST_SEQ_TIMEOUT_EN
    logic [timeout_width_p-1:0]  timer_q, timer_d;
    logic                        timeout_q, timeout_d;
`else
    logic [timeout_width_p-1:0]  unused_timer_cfg;
    assign unused_timer_cfg = '0;
`endif

    // Mux the active node's counters and error flag.
    always_comb begin
        sent_sel = '0;
        recv_sel = '0;
        err_sel  = 1'b0;
        for (int i = 0; i < int'(num_nodes_p); i++) begin
            if (idx_q == node_id_width_lp'(i)) begin
                sent_sel = sent_i[i*count_width_p +: count_width_p];
                recv_sel = received_i[i*count_width_p +: count_width_p];
                err_sel  = error_i[i];
            end
        end
    end

    // Modular deltas keep counter wrap transparent.
    assign ds        = sent_sel - base_s_q;
    assign dr        = recv_sel - base_r_q;
    assign last_node = (idx_q == node_id_width_lp'(num_nodes_p - 1));

    always_comb begin
        en_o = '0;
        for (int i = 0; i < int'(num_nodes_p); i++) begin
            en_o[i] = (state_q == SEND) && (idx_q == node_id_width_lp'(i)) && (ds < burst_q);
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        burst_d     = burst_q;
        base_s_d    = base_s_q;
        base_r_d    = base_r_q;
        busy_d      = busy_q;
        done_d      = done_q;
        pass_d      = pass_q;
        fail_node_d = fail_node_q;
`ifdef BSG_SDR_TEST_SEQ_TIMEOUT_EN
        timer_d     = timer_q;
        timeout_d   = timeout_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d     = LOAD;
                    burst_d     = burst_len_i;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    pass_d      = 1'b0;
                    fail_node_d = '0;
`ifdef BSG_SDR_TEST_SEQ_TIMEOUT_EN
                    timeout_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                base_s_d = sent_sel;
                base_r_d = recv_sel;
                state_d  = SEND;
            end
            SEND: begin
                if (ds >= burst_q) begin
                    state_d = DRAIN;
`ifdef BSG_SDR_TEST_SEQ_TIMEOUT_EN
                    timer_d = '0;
`endif
                end
            end
            DRAIN: begin
                if (dr == burst_q) begin
                    state_d = CHECK;
                end
`ifdef BSG_SDR_TEST_SEQ_TIMEOUT_EN
                else if (timer_q == '1) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_node_d = idx_q;
                    timeout_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            CHECK: begin
                if (err_sel) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_node_d = idx_q;
                end else if (last_node) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = 1'b1;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            burst_q     <= '0;
            base_s_q    <= '0;
            base_r_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_node_q <= '0;
`ifdef BSG_SDR_TEST_SEQ_TIMEOUT_EN
            timer_q     <= '0;
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            burst_q     <= burst_d;
            base_s_q    <= base_s_d;
            base_r_q    <= base_r_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_node_q <= fail_node_d;
`ifdef BSG_SDR_TEST_SEQ_TIMEOUT_EN
            timer_q     <= timer_d;
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_node_o = fail_node_q;
`ifdef BSG_SDR_TEST_SEQ_TIMEOUT_EN
    assign timeout_o   = timeout_q;
`else
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_sdr_test_node_sequencer.sv
// Bench for bsg_sdr_test_node_sequencer: random-backpressure loopback nodes plus an outcome model.
`timescale 1ns/1ps
module tb_bsg_sdr_test_node_sequencer;

    localparam int unsigned NN  = 4;
    localparam int unsigned CW  = 32;
    localparam int unsigned TW  = 4;
    localparam int unsigned IDW = 2;
    localparam int unsigned BUDGET = 3000;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [CW-1:0]   burst_len = '0;
    logic [NN-1:0]   en;
    logic [NN*CW-1:0] sent_bus, recv_bus;
    logic [NN-1:0]   err_bus;
    logic            busy, done, pass, timeout;
    logic [IDW-1:0]  fail_node;

    bsg_sdr_test_node_sequencer #(
        .num_nodes_p(NN), .count_width_p(CW), .timeout_width_p(TW)
    ) dut (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(start), .burst_len_i(burst_len),
        .en_o(en), .sent_i(sent_bus), .received_i(recv_bus), .error_i(err_bus),
        .busy_o(busy), .done_o(done), .pass_o(pass), .fail_node_o(fail_node),
        .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    // Node model state: totals owned by the node process, configuration owned by the tests.
    logic [CW-1:0] acc_total [NN] = '{default: '0};
    logic [CW-1:0] rsp_total [NN] = '{default: '0};
    logic [CW-1:0] sent_off  [NN] = '{default: '0};
    logic [CW-1:0] recv_off  [NN] = '{default: '0};
    logic [CW-1:0] rsp_base  [NN] = '{default: '0};
    logic [CW-1:0] err_k     [NN] = '{default: '0};
    logic          hold      [NN] = '{default: 1'b0};
    logic [CW-1:0] hold_at = '0;

    always_comb begin
        for (int i = 0; i < NN; i++) begin
            sent_bus[i*CW +: CW] = sent_off[i] + acc_total[i];
            recv_bus[i*CW +: CW] = recv_off[i] + rsp_total[i];
            err_bus[i] = (err_k[i] != 0) && ((rsp_total[i] - rsp_base[i]) >= err_k[i]);
        end
    end

    // Loopback nodes: random accept while enabled, random in-order response return.
    always @(posedge clk) begin
        for (int i = 0; i < NN; i++) begin
            if (en[i] && ($urandom_range(3) != 0))
                acc_total[i] <= acc_total[i] + 1;
            if ((rsp_total[i] != acc_total[i]) && ($urandom_range(1) == 1) &&
                !(hold[i] && ((rsp_total[i] - rsp_base[i]) >= hold_at)))
                rsp_total[i] <= rsp_total[i] + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int obs_acc [NN];
    int exp_acc [NN];
    int obs_onehot, obs_order, obs_cycles, obs_last_en1, obs_en_cycles;
    bit obs_timed_out, obs_busy;

    task automatic configure(input int err_node, input int unsigned k, input int hold_node,
                             input int unsigned burst);
        for (int i = 0; i < NN; i++) begin
            err_k[i] = (i == err_node) ? CW'(k) : '0;
            hold[i]  = (i == hold_node);
        end
        hold_at = (burst > 0) ? CW'(burst - 1) : '0;
    endtask

    // Outcome from the sequencing rules: nodes in order, stop at first error or stall.
    task automatic model(input int unsigned burst, input int err_node, input int unsigned k,
                         input int hold_node, output bit ep, output int ef, output bit eto);
        ep = 1'b1; ef = 0; eto = 1'b0;
        for (int i = 0; i < NN; i++) exp_acc[i] = 0;
        for (int i = 0; i < NN; i++) begin
            exp_acc[i] = int'(burst);
            if (i == hold_node && burst > 0) begin ep = 1'b0; ef = i; eto = 1'b1; break; end
            if (i == err_node && k >= 1 && k <= burst) begin ep = 1'b0; ef = i; break; end
        end
    endtask

    task automatic do_run(input int unsigned burst, input bit pulse_mid);
        logic [CW-1:0] acc0 [NN];
        int last_node;
        for (int i = 0; i < NN; i++) begin
            acc0[i] = acc_total[i];
            rsp_base[i] = rsp_total[i];
        end
        obs_onehot = 0; obs_order = 0; obs_last_en1 = -1; obs_en_cycles = 0;
        @(negedge clk);
        burst_len = CW'(burst);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        burst_len = CW'($urandom);
        obs_busy = busy;
        obs_cycles = 1;
        last_node = 0;
        while (!done && obs_cycles < BUDGET) begin
            if ($countones(en) > 1) obs_onehot++;
            if (en != '0) obs_en_cycles++;
            for (int i = 0; i < NN; i++) begin
                if (en[i]) begin
                    if (i < last_node) obs_order++;
                    last_node = i;
                    if (i == 1) obs_last_en1 = obs_cycles;
                end
            end
            start = (pulse_mid && obs_cycles == 20);
            @(negedge clk);
            obs_cycles++;
        end
        start = 1'b0;
        obs_timed_out = !done;
        for (int i = 0; i < NN; i++) obs_acc[i] = int'(acc_total[i] - acc0[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_chk++; if (en !== '0) begin n_fail++; $display("FAIL reset.en got %b want 0", en); end
        n_chk++; if ({busy, done, pass, timeout} !== 4'b0) begin n_fail++;
            $display("FAIL reset.flags got busy=%b done=%b pass=%b to=%b want 0", busy, done, pass, timeout); end
        n_chk++; if (fail_node !== '0) begin n_fail++; $display("FAIL reset.fail_node got %0d want 0", fail_node); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_full_pass();
        configure(-1, 0, -1, 16);
        do_run(16, 1'b0);
        n_chk++; if (obs_timed_out) begin n_fail++; $display("FAIL full.timeout_wait got no done want done"); end
        n_chk++; if (obs_busy !== 1'b1) begin n_fail++; $display("FAIL full.busy got %b want 1", obs_busy); end
        n_chk++; if ({done, pass, timeout} !== 3'b110) begin n_fail++;
            $display("FAIL full.result got done=%b pass=%b to=%b want 1 1 0", done, pass, timeout); end
        n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full.busy_end got %b want 0", busy); end
        for (int i = 0; i < NN; i++) begin
            n_chk++; if (obs_acc[i] !== 16) begin n_fail++;
                $display("FAIL full.accepts node %0d got %0d want 16", i, obs_acc[i]); end
        end
        n_chk++; if (obs_onehot + obs_order !== 0) begin n_fail++;
            $display("FAIL full.en_order got onehot_viol=%0d order_viol=%0d want 0", obs_onehot, obs_order); end
        idle(30);
    endtask

    task automatic test_error_node();
        configure(2, 5, -1, 16);
        do_run(16, 1'b0);
        n_chk++; if ({done, pass, timeout} !== 3'b100 || fail_node !== 2'd2) begin n_fail++;
            $display("FAIL err.result got done=%b pass=%b to=%b node=%0d want 1 0 0 2", done, pass, timeout, fail_node); end
        n_chk++; if (obs_acc[3] !== 0) begin n_fail++; $display("FAIL err.node3 got %0d accepts want 0", obs_acc[3]); end
        n_chk++; if (obs_acc[2] !== 16) begin n_fail++; $display("FAIL err.node2 got %0d accepts want 16", obs_acc[2]); end
        configure(-1, 0, -1, 16);
        idle(30);
    endtask

    task automatic test_zero_burst();
        configure(-1, 0, -1, 0);
        do_run(0, 1'b0);
        n_chk++; if (obs_en_cycles !== 0) begin n_fail++; $display("FAIL zero.en got %0d enabled cycles want 0", obs_en_cycles); end
        n_chk++; if ({done, pass} !== 2'b11) begin n_fail++; $display("FAIL zero.result got done=%b pass=%b want 1 1", done, pass); end
        n_chk++; if (obs_cycles > 4 * NN + 2) begin n_fail++;
            $display("FAIL zero.latency got %0d cycles want <= %0d", obs_cycles, 4 * NN + 2); end
    endtask

    task automatic test_wrap_and_ignored_start();
        configure(-1, 0, -1, 16);
        for (int i = 0; i < NN; i++) begin
            sent_off[i] = 32'hFFFF_FFF8 - acc_total[i];
            recv_off[i] = 32'hFFFF_FFF8 - rsp_total[i];
        end
        do_run(16, 1'b1);
        n_chk++; if ({done, pass, timeout} !== 3'b110) begin n_fail++;
            $display("FAIL wrap.result got done=%b pass=%b to=%b want 1 1 0", done, pass, timeout); end
        for (int i = 0; i < NN; i++) begin
            n_chk++; if (obs_acc[i] !== 16) begin n_fail++;
                $display("FAIL wrap.accepts node %0d got %0d want 16", i, obs_acc[i]); end
        end
        idle(30);
    endtask

    task automatic test_reset_mid_run();
        int wait_cyc;
        configure(-1, 0, -1, 16);
        @(negedge clk);
        burst_len = 16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc = 0;
        while (!en[1] && wait_cyc < BUDGET) begin @(negedge clk); wait_cyc++; end
        n_chk++; if (en[1] !== 1'b1) begin n_fail++; $display("FAIL rstmid.reach_node1 got en=%b want bit1 set", en); end
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if (en !== '0) begin n_fail++; $display("FAIL rstmid.en got %b want 0", en); end
        n_chk++; if ({busy, done, pass, timeout} !== 4'b0 || fail_node !== '0) begin n_fail++;
            $display("FAIL rstmid.flags got busy=%b done=%b pass=%b to=%b node=%0d want 0", busy, done, pass, timeout, fail_node); end
        idle(3);
        rst_n = 1'b1;
        idle(60);
        do_run(16, 1'b0);
        n_chk++; if ({done, pass, timeout} !== 3'b110) begin n_fail++;
            $display("FAIL rstmid.rerun got done=%b pass=%b to=%b want 1 1 0", done, pass, timeout); end
        for (int i = 0; i < NN; i++) begin
            n_chk++; if (obs_acc[i] !== 16) begin n_fail++;
                $display("FAIL rstmid.accepts node %0d got %0d want 16", i, obs_acc[i]); end
        end
        idle(30);
    endtask

`ifdef BSG_SDR_TEST_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        configure(-1, 0, 1, 16);
        do_run(16, 1'b0);
        n_chk++; if ({done, pass, timeout} !== 3'b101 || fail_node !== 2'd1) begin n_fail++;
            $display("FAIL tmo.result got done=%b pass=%b to=%b node=%0d want 1 0 1 1", done, pass, timeout, fail_node); end
        n_chk++; if (obs_cycles - obs_last_en1 !== 18) begin n_fail++;
            $display("FAIL tmo.latency got %0d cycles after last enable want 18", obs_cycles - obs_last_en1); end
        n_chk++; if (obs_acc[2] !== 0) begin n_fail++; $display("FAIL tmo.node2 got %0d accepts want 0", obs_acc[2]); end
        configure(-1, 0, -1, 16);
        idle(60);
    endtask
`endif

    task automatic test_random();
        int unsigned burst, k;
        int err_node, ef;
        bit ep, eto;
        for (int it = 0; it < 8; it++) begin
            burst = $urandom_range(10);
            err_node = int'($urandom_range(NN)) - 1;
            k = $urandom_range(burst + 2, 1);
            configure(err_node, k, -1, burst);
            model(burst, err_node, k, -1, ep, ef, eto);
            do_run(burst, 1'b0);
            n_chk++; if (done !== 1'b1 || pass !== ep || timeout !== eto) begin n_fail++;
                $display("FAIL rand%0d.result got done=%b pass=%b to=%b want 1 %b %b", it, done, pass, timeout, ep, eto); end
            if (!ep) begin
                n_chk++; if (fail_node !== IDW'(ef)) begin n_fail++;
                    $display("FAIL rand%0d.fail_node got %0d want %0d", it, fail_node, ef); end
            end
            for (int i = 0; i < NN; i++) begin
                n_chk++; if (obs_acc[i] !== exp_acc[i]) begin n_fail++;
                    $display("FAIL rand%0d.accepts node %0d got %0d want %0d", it, i, obs_acc[i], exp_acc[i]); end
            end
            configure(-1, 0, -1, 0);
            idle(30);
        end
    endtask

    initial begin
        test_reset();
        test_full_pass();
        test_error_node();
        test_zero_burst();
        test_wrap_and_ignored_start();
        test_reset_mid_run();
`ifdef BSG_SDR_TEST_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
